fft_butterfly_sequencer: RTL and testbench
==========================================

Name: fft_butterfly_sequencer

Overview:
Control-side counterpart of the FFT butterfly unit. For an N-point in-place transform it:
- generates coefficient-memory read addresses and twiddle addresses;
- issues bf_start at the cycle the unbuffered butterfly inputs are valid;
- tracks in-flight butterflies through a fixed-latency delay line;
- emits write-back addresses exactly when butterfly results appear.

Supports GS (DIF) and CT (DIT) stage ordering, with a drain barrier between stages.

Parameters:
LOG_N, 10, log2 of transform size N; N/2 butterflies per stage, LOG_N stages.
RD_LATENCY, 2, cycles from rd_en/rd_addr to data valid at butterfly inputs (min 1).
BF_LATENCY, 20, cycles from bf_start to butterfly done/outputs valid (min 1).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
go  in  1  start-transform pulse; ignored while busy.
use_ct  in  1  ordering select, sampled with go: 1 = CT/DIT, 0 = GS/DIF.
bf_done  in  1  done pulse from butterfly, checked against the expected schedule.
rd_en  out  1  coefficient read strobe.
rd_addr_a  out  LOG_N  read address of upper operand.
rd_addr_b  out  LOG_N  read address of lower operand.
tw_addr  out  LOG_N-1  twiddle ROM index, aligned with rd_en.
bf_start  out  1  butterfly start = rd_en delayed RD_LATENCY cycles.
bf_use_ct  out  1  latched use_ct, held for the whole transform.
wr_en  out  1  result write strobe.
wr_addr_a  out  LOG_N  write address for a_out.
wr_addr_b  out  LOG_N  write address for b_out.
busy  out  1  transform in progress.
done  out  1  one-cycle pulse after final write.
err  out  1  sticky schedule-mismatch flag.

Behaviour:
- Reset: all outputs 0. FSM to IDLE. Counters, delay line, and err cleared. In-flight butterflies are discarded; no write issued after a mid-transform reset.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on go, latch use_ct into bf_use_ct, clear err, set stage s=0 and k=0, go to ISSUE.
- busy is high from the cycle after go through the done cycle inclusive.
- ISSUE: one butterfly per cycle, rd_en=1. k counts 0..N/2-1. After k=N/2-1, go to DRAIN.
- Address generation per (s,k):
  - GS: h = N>>(s+1). CT: h = 1<<s.
  - j = k mod h, g = k div h.
  - rd_addr_a = 2*h*g + j; rd_addr_b = rd_addr_a + h.
  - GS: tw_addr = j<<s. CT: tw_addr = j<<(LOG_N-1-s).
  - Shifts and multiplies by powers of two only; no arithmetic dividers.
- Delay line depth RD_LATENCY+BF_LATENCY carries {valid, addr_a, addr_b}.
  - bf_start taps at depth RD_LATENCY.
  - wr_en, wr_addr_a, and wr_addr_b tap at the full depth.
  - Result: wr_addr equals rd_addr of the same butterfly, written in place.
- DRAIN: rd_en=0 until the delay line is empty, i.e. the last wr_en of the stage has occurred. The next cycle then either:
  - starts stage s+1 in ISSUE, with the first rd_en one cycle after the last wr_en; or
  - if s=LOG_N-1, goes to FINISH.
- FINISH: done=1 and busy=1 for one cycle, then IDLE.
- Stage period = N/2 + RD_LATENCY + BF_LATENCY cycles. Total from first rd_en to done = LOG_N times the stage period.
- Check: in every cycle, bf_done must equal the valid bit at the full delay-line depth. Any mismatch sets err.
  - err stays set until rst or the next accepted go.
  - A mismatch does not alter sequencing.
- go while busy: ignored. go and rst in the same cycle: rst wins.

Test Plan:
- LOG_N=3, RD=2, BF=4, GS, go at cycle C: stage0 (a,b,tw) = (0,4,0),(1,5,1),(2,6,2),(3,7,3) at C+1..C+4. bf_start at C+3..C+6. wr_en at C+7..C+10 with matching addresses.
- Same config, full GS run: stage1 = (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage2 = (0,1,0),(2,3,0),(4,5,0),(6,7,0). Stage starts at C+1, C+11, C+21. done at C+31; busy low at C+32.
- Same config, CT: stage0 = (0,1,0),(2,3,0),(4,5,0),(6,7,0); stage2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3). bf_use_ct=1 throughout.
- bf_done driven as the model echo gives err=0. Drop one bf_done pulse gives err=1 from the next cycle and stays 1; done still occurs at C+31. A new go clears err.
- rst asserted at C+8 mid-stage: all outputs 0 at C+9. No wr_en afterwards. A new go restarts from stage0, k=0.
- go pulsed at C+5 during busy: no effect on addresses or timing. go and rst in the same cycle: stays IDLE.

Source files
------------

// File: rtl/fft_butterfly_sequencer.sv
// FFT butterfly sequencer: read/twiddle address generation, butterfly issue,
// in-flight tracking and in-place write-back for GS (DIF) or CT (DIT) order.
module fft_butterfly_sequencer #(
  parameter int LOG_N      = 10,
  parameter int RD_LATENCY = 2,
  parameter int BF_LATENCY = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             use_ct,
  input  logic             bf_done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             bf_start,
  output logic             bf_use_ct,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int D  = RD_LATENCY + BF_LATENCY;
  localparam int SW = $clog2(LOG_N + 1);
  localparam int KW = LOG_N - 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  typedef struct packed {
    logic             v;
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } dl_t;

  state_t          state, state_n;
  logic [SW-1:0]   s;
  logic [KW-1:0]   k;
  logic            use_ct_q;
  logic            err_q;
  dl_t             dl [D];

  logic            k_last;
  logic            s_last;
  logic            empty_n;
  logic [SW-1:0]   sh;
  logic [SW-1:0]   twsh;
  logic [LOG_N-1:0] kx;
  logic [LOG_N-1:0] h;
  logic [LOG_N-1:0] j;
  logic [LOG_N-1:0] a;
  logic [LOG_N-1:0] tw_full;

  assign k_last = (k == {KW{1'b1}});
  assign s_last = (s == SW'(LOG_N - 1));

  // Line is empty after this edge when nothing sits below the output tap.
  always_comb begin
    empty_n = 1'b1;
    for (int i = 0; i < D - 1; i++) begin
      if (dl[i].v) empty_n = 1'b0;
    end
  end

  // Butterfly span is a power of two, so index split is mask and shift.
  always_comb begin
    sh      = use_ct_q ? s : SW'(LOG_N - 1) - s;
    twsh    = use_ct_q ? SW'(LOG_N - 1) - s : s;
    kx      = {1'b0, k};
    h       = LOG_N'(1) << sh;
    j       = kx & (h - LOG_N'(1));
    a       = (((kx >> sh) << sh) << 1) | j;
    tw_full = j << twsh;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control outputs.
  always_comb begin
    state_n   = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    unique case (state)
      IDLE: begin
        if (go) state_n = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr_a = a;
        rd_addr_b = a | h;
        tw_addr   = tw_full[LOG_N-2:0];
        if (k_last) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (empty_n) state_n = s_last ? FINISH : ISSUE;
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage/butterfly counters and the latched ordering select.
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '0;
      k        <= '0;
      use_ct_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            s        <= '0;
            k        <= '0;
            use_ct_q <= use_ct;
          end
        end
        ISSUE: k <= k + KW'(1);
        DRAIN: begin
          if (empty_n && !s_last) s <= s + SW'(1);
        end
        default: ;
      endcase
    end
  end

  // In-flight delay line; idle slots carry zero addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) dl[i] <= '0;
    end else begin
      dl[0] <= '{v: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
    end
  end

  // Sticky schedule check of bf_done against the expected completion.
  always_ff @(posedge clk) begin
    if (rst)                      err_q <= 1'b0;
    else if (state == IDLE && go) err_q <= 1'b0;
    else if (bf_done != dl[D-1].v) err_q <= 1'b1;
  end

  assign bf_start  = dl[RD_LATENCY-1].v;
  assign wr_en     = dl[D-1].v;
  assign wr_addr_a = dl[D-1].a;
  assign wr_addr_b = dl[D-1].b;
  assign bf_use_ct = use_ct_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Bench for fft_butterfly_sequencer: cycle-indexed schedule model,
// directed and randomized runs with dropped pulses, resets and stray go.
module tb_fft_butterfly_sequencer;

  localparam int LOG_N = 3;
  localparam int RD    = 2;
  localparam int BF    = 4;
  localparam int N     = 1 << LOG_N;
  localparam int HALF  = N / 2;
  localparam int P     = HALF + RD + BF;
  localparam int T     = LOG_N * P;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             use_ct;
  logic             bf_done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-2:0] tw_addr;
  logic             bf_start;
  logic             bf_use_ct;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;
  logic             busy;
  logic             done;
  logic             err;

  int vectors = 0;
  int miscompares = 0;
  bit m_uct;
  bit m_err;

  fft_butterfly_sequencer #(
    .LOG_N(LOG_N),
    .RD_LATENCY(RD),
    .BF_LATENCY(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .use_ct(use_ct),
    .bf_done(bf_done),
    .rd_en(rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr),
    .bf_start(bf_start),
    .bf_use_ct(bf_use_ct),
    .wr_en(wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_start, bf_use_ct,
                wr_en, wr_addr_a, wr_addr_b, busy, done, err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue slot u (cycles since first read): stage and butterfly index.
  function automatic void slot(input int u, output bit v,
                               output int s, output int k);
    v = 1'b0;
    s = 0;
    k = 0;
    if (u >= 0 && u < T) begin
      s = u / P;
      k = u % P;
      v = (k < HALF);
    end
  endfunction

  function automatic void bfly(input int s, input int k, input bit ct,
                               output int a, output int b, output int tw);
    int h;
    int jj;
    int g;
    h  = ct ? (1 << s) : (N >> (s + 1));
    jj = k % h;
    g  = k / h;
    a  = 2 * h * g + jj;
    b  = a + h;
    tw = ct ? (jj << (LOG_N - 1 - s)) : (jj << s);
  endfunction

  function automatic bit wr_due(input int t);
    bit v;
    int s;
    int k;
    slot(t - 1 - RD - BF, v, s, k);
    return v;
  endfunction

  // Expected outputs in cycle t after go (t=0 means idle).
  function automatic logic [20:0] expv(input int t, input bit ct,
                                       input bit uct, input bit e);
    bit rv, bv, wv, bz, dn;
    int rs, rk, bs, bk, ws, wk;
    int ra, rb, rt, wa, wb, x;
    ra = 0; rb = 0; rt = 0; wa = 0; wb = 0; x = 0;
    slot(t - 1, rv, rs, rk);
    slot(t - 1 - RD, bv, bs, bk);
    slot(t - 1 - RD - BF, wv, ws, wk);
    if (t < 1) begin
      rv = 1'b0; bv = 1'b0; wv = 1'b0;
    end
    if (rv) bfly(rs, rk, ct, ra, rb, rt);
    if (wv) bfly(ws, wk, ct, wa, wb, x);
    bz = (t >= 1 && t <= T + 1);
    dn = (t == T + 1);
    return {rv, 3'(ra), 3'(rb), 2'(rt), bv, uct,
            wv, 3'(wa), 3'(wb), bz, dn, e};
  endfunction

  task automatic chk(input string tag, input logic [20:0] e);
    vectors++;
    assert (obs === e)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic idle(input int n, input string tag);
    go = 1'b0;
    bf_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, expv(0, 1'b0, m_uct, m_err));
    end
  endtask

  task automatic run(input bit ct, input int drop_t,
                     input int rst_t, input int spur_t);
    bit dead;
    bit wrx;
    dead = 1'b0;
    go = 1'b1;
    use_ct = ct;
    rst = 1'b0;
    bf_done = 1'b0;
    tick();
    go = 1'b0;
    m_uct = ct;
    m_err = 1'b0;
    for (int t = 1; t <= T + 3; t++) begin
      chk($sformatf("run ct=%0d t=%0d", ct, t),
          expv(dead ? 0 : t, ct, m_uct, m_err));
      wrx = !dead && wr_due(t);
      bf_done = wrx && (t != drop_t);
      go = (t == spur_t);
      use_ct = 1'($urandom_range(0, 1));
      rst = (t == rst_t);
      if (rst) begin
        dead = 1'b1;
        m_err = 1'b0;
        m_uct = 1'b0;
      end else if (bf_done != wrx) begin
        m_err = 1'b1;
      end
      tick();
    end
    go = 1'b0;
    rst = 1'b0;
    bf_done = 1'b0;
  endtask

  initial begin
    int ct, dr, rt, sp;
    rst = 1'b1;
    go = 1'b0;
    use_ct = 1'b0;
    bf_done = 1'b0;
    m_uct = 1'b0;
    m_err = 1'b0;
    tick();
    tick();
    chk("reset", expv(0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    idle(2, "post_reset");

    run(1'b0, 0, 0, 0);
    run(1'b1, 0, 0, 0);
    run(1'b0, 8, 0, 5);
    idle(3, "err_sticky");
    run(1'b1, 0, 0, 0);
    run(1'b0, 0, 8, 0);
    idle(2, "after_rst");

    go = 1'b1;
    rst = 1'b1;
    use_ct = 1'b1;
    tick();
    go = 1'b0;
    rst = 1'b0;
    m_uct = 1'b0;
    m_err = 1'b0;
    chk("go_rst", expv(0, 1'b0, m_uct, m_err));
    idle(2, "go_rst_idle");
    run(1'b0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      ct = $urandom_range(0, 1);
      dr = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, T);
      rt = ($urandom_range(0, 3) == 0) ? $urandom_range(3, T) : 0;
      sp = $urandom_range(2, (rt != 0) ? rt - 1 : T);
      run(ct[0], dr, rt, sp);
      idle(2, "rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
